alu_sequencer: RTL and testbench

//  Program sequencer directly upstream of the 8-bit ALU. Fetches 4-byte instructions

---
 rtl/alu_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches 4-byte instructions, feeds the 8-bit ALU,
// waits out its latency and writes the result back to RAM.
module alu_sequencer #(
    parameter int unsigned    AW       = 8,
    parameter int unsigned    ALU_LAT  = 2,
    parameter logic [AW-1:0]  START_PC = '0,
    parameter logic [7:0]     HALT_OP  = 8'hFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] memAddr,
    output logic          memRd,
    input  logic [7:0]    memRdData,
    output logic          memWr,
    output logic [7:0]    memWrData,
    output logic [7:0]    aluA,
    output logic [7:0]    aluB,
    output logic [7:0]    aluInst,
    input  logic [7:0]    aluResult,
    input  logic          carryFlag,
    input  logic          compFlag,
    output logic [1:0]    flags,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ALU_LAT - 1);

    // The dst byte is captured in RA while the srcA read is issued, since
    // dst is not needed until WB; this keeps an instruction at 12+ALU_LAT.
    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_C0, S_F1, S_C1, S_F2, S_C2, S_F3,
        S_RA, S_CA, S_RB, S_CB, S_EX, S_WB, S_HALT
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    op_q, op_d;
    logic [AW-1:0] srca_q, srca_d;
    logic [AW-1:0] srcb_q, srcb_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    inst_q, inst_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [1:0]    flags_q, flags_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and datapath registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            op_q    <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            inst_q  <= '0;
            wdata_q <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            inst_q  <= inst_d;
            wdata_q <= wdata_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and memory strobes for each sequencer step.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        dst_d   = dst_q;
        a_d     = a_q;
        b_d     = b_q;
        inst_d  = inst_q;
        wdata_d = wdata_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        memAddr = '0;
        memRd   = 1'b0;
        memWr   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = START_PC;
                    state_d = S_F0;
                end
            end
            S_F0: begin
                memAddr = pc_q;
                memRd   = 1'b1;
                state_d = S_C0;
            end
            S_C0: begin
                op_d    = memRdData;
                state_d = (memRdData == HALT_OP) ? S_HALT : S_F1;
            end
            S_F1: begin
                memAddr = pc_q + AW'(1);
                memRd   = 1'b1;
                state_d = S_C1;
            end
            S_C1: begin
                srca_d  = AW'(memRdData);
                state_d = S_F2;
            end
            S_F2: begin
                memAddr = pc_q + AW'(2);
                memRd   = 1'b1;
                state_d = S_C2;
            end
            S_C2: begin
                srcb_d  = AW'(memRdData);
                state_d = S_F3;
            end
            S_F3: begin
                memAddr = pc_q + AW'(3);
                memRd   = 1'b1;
                state_d = S_RA;
            end
            S_RA: begin
                dst_d   = AW'(memRdData);
                memAddr = srca_q;
                memRd   = 1'b1;
                state_d = S_CA;
            end
            S_CA: begin
                a_d     = memRdData;
                state_d = S_RB;
            end
            S_RB: begin
                memAddr = srcb_q;
                memRd   = 1'b1;
                state_d = S_CB;
            end
            S_CB: begin
                b_d     = memRdData;
                inst_d  = op_q;
                cnt_d   = '0;
                state_d = S_EX;
            end
            S_EX: begin
                if (cnt_q == LAST) begin
                    wdata_d = aluResult;
                    flags_d = {compFlag, carryFlag};
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                memAddr = dst_q;
                memWr   = 1'b1;
                pc_d    = pc_q + AW'(4);
                state_d = S_F0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign memWrData = wdata_q;
    assign aluA      = a_q;
    assign aluB      = b_q;
    assign aluInst   = inst_q;
    assign flags     = flags_q;
    assign pc        = pc_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done      = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: three sequencers (different ALU latency / start pc)
// with RAM and ALU models; writes are checked against a scoreboard.
module tb_alu_sequencer;

    function automatic int lat_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 5 : 2;
    endfunction

    function automatic logic [7:0] spc_of(input int k);
        return (k == 1) ? 8'hFE : 8'h00;
    endfunction

    // Model ALU: {comp, carry, result}
    function automatic logic [9:0] alu_f(input logic [7:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [8:0] s;
        case (op)
            8'h01: begin
                s = {1'b0, a} + {1'b0, b};
                return {1'b0, s[8], s[7:0]};
            end
            8'h02: begin
                s = {1'b0, a} - {1'b0, b};
                return {1'b1, s[8], s[7:0]};
            end
            default: return {1'b1, 1'b0, a ^ b};
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst_n [3];
    logic       start [3];
    logic [7:0] maddr [3];
    logic       mrd   [3];
    logic [7:0] rdat  [3];
    logic       mwr   [3];
    logic [7:0] wdat  [3];
    logic [7:0] aa    [3];
    logic [7:0] ab    [3];
    logic [7:0] ai    [3];
    logic [7:0] ares  [3];
    logic       cf    [3];
    logic       cpf   [3];
    logic [1:0] fl    [3];
    logic [7:0] pcv   [3];
    logic       busy  [3];
    logic       done  [3];
    logic [7:0] ram   [3][256];

    int nchk = 0;
    int nfail = 0;
    logic [17:0] expq [$];
    logic [7:0]  rdlog [$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int LAT  = lat_of(k);
        localparam int PIDX = (LAT > 1) ? LAT - 2 : 0;
        logic [9:0] comb;
        logic [9:0] pipe [8];
        logic [9:0] sel;

        alu_sequencer #(
            .AW(8), .ALU_LAT(LAT), .START_PC(spc_of(k)), .HALT_OP(8'hFF)
        ) dut (
            .clk(clk), .rst_n(rst_n[k]), .start(start[k]),
            .memAddr(maddr[k]), .memRd(mrd[k]), .memRdData(rdat[k]),
            .memWr(mwr[k]), .memWrData(wdat[k]),
            .aluA(aa[k]), .aluB(ab[k]), .aluInst(ai[k]),
            .aluResult(ares[k]), .carryFlag(cf[k]), .compFlag(cpf[k]),
            .flags(fl[k]), .pc(pcv[k]), .busy(busy[k]), .done(done[k])
        );

        assign comb = alu_f(ai[k], aa[k], ab[k]);
        assign sel  = (LAT == 1) ? comb : pipe[PIDX];
        assign ares[k] = sel[7:0];
        assign cf[k]   = sel[8];
        assign cpf[k]  = sel[9];

        always @(posedge clk) begin
            if (mrd[k]) rdat[k] <= ram[k][maddr[k]];
            pipe[0] <= comb;
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        logic [17:0] e, got;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (mrd[k] && mwr[k]) begin
                nfail++;
                $display("FAIL strobes: inst %0d rd and wr both high", k);
            end
            if (k == 1 && mrd[k]) rdlog.push_back(maddr[k]);
            if (mwr[k]) begin
                got = {2'(k), maddr[k], wdat[k]};
                if (expq.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_write: got %0h expected none", got);
                end else begin
                    e = expq.pop_front();
                    check("write", got, e);
                end
            end
        end
    endtask

    task automatic chk_idle(input int k, input logic [7:0] pce);
        check("rst_strobes", {mrd[k], mwr[k], busy[k], done[k]}, 0);
        check("rst_addr_wdata", {maddr[k], wdat[k], fl[k]}, 0);
        check("rst_alu", {aa[k], ab[k], ai[k]}, 0);
        check("rst_pc", pcv[k], pce);
    endtask

    task automatic load_prog(input int k, input logic [7:0] base,
                             input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] b);
        ram[k][base]         = op;
        ram[k][base + 8'd1]  = 8'd10;
        ram[k][base + 8'd2]  = 8'd11;
        ram[k][base + 8'd3]  = 8'd12;
        ram[k][base + 8'd4]  = 8'hFF;
        ram[k][10]           = a;
        ram[k][11]           = b;
    endtask

    task automatic run(input int k, input int maxc, output int n);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        n = 0;
        while (!done[k] && n < maxc) begin
            tick();
            n++;
        end
        if (!done[k]) begin
            nfail++;
            $display("FAIL timeout: inst %0d done=0 after %0d cycles", k, n);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [1:0] fl;
    } vec_t;

    vec_t vec [6];

    initial begin
        int n;
        logic [7:0] npc;
        vec[0] = '{0, 8'h01, 8'hF0, 8'h20, 8'h10, 2'b01};
        vec[1] = '{0, 8'h01, 8'h12, 8'h34, 8'h46, 2'b00};
        vec[2] = '{0, 8'h02, 8'h05, 8'h07, 8'hFE, 2'b11};
        vec[3] = '{0, 8'h37, 8'h3C, 8'h0F, 8'h33, 2'b10};
        vec[4] = '{1, 8'h01, 8'h80, 8'h80, 8'h00, 2'b01};
        vec[5] = '{2, 8'h02, 8'h10, 8'h01, 8'h0F, 2'b10};
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            start[k] = 1'b0;
            for (int i = 0; i < 256; i++) ram[k][i] = 8'h00;
        end

        tick();
        tick();
        for (int k = 0; k < 3; k++) chk_idle(k, spc_of(k));
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();

        // Asynchronous reset in the middle of EX
        load_prog(0, 8'h00, 8'h01, 8'hF0, 8'h20);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("in_ex_busy", busy[0], 1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk_idle(0, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        rst_n[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("after_rst_idle", {busy[0], done[0]}, 0);
        expq.push_back({2'd0, 8'd12, 8'h10});
        run(0, 100, n);
        check("rerun_cycles", n, 16);
        check("rerun_pc", pcv[0], 8'h04);
        check("rerun_flags", fl[0], 2'b01);
        check("rerun_pending", expq.size(), 0);

        // Table-driven instructions on all three latency/pc variants
        foreach (vec[i]) begin
            load_prog(vec[i].k, spc_of(vec[i].k), vec[i].op, vec[i].a, vec[i].b);
            expq.push_back({2'(vec[i].k), 8'd12, vec[i].res});
            rdlog.delete();
            run(vec[i].k, 100, n);
            npc = spc_of(vec[i].k) + 8'd4;
            check("vec_cycles", n, 14 + lat_of(vec[i].k));
            check("vec_flags", fl[vec[i].k], vec[i].fl);
            check("vec_pc", pcv[vec[i].k], npc);
            check("vec_done_busy", {done[vec[i].k], busy[vec[i].k]}, 2'b10);
            check("vec_pending", expq.size(), 0);
            if (vec[i].k == 1) begin
                if (rdlog.size() < 4) begin
                    nchk++;
                    nfail++;
                    $display("FAIL wrap_reads: got %0d reads expected 4+", rdlog.size());
                end else begin
                    check("wrap_reads", {rdlog[0], rdlog[1], rdlog[2], rdlog[3]},
                          32'hFEFF0001);
                end
            end
        end

        // Immediate HALT
        ram[0][0] = 8'hFF;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        check("halt_not_yet", done[0], 0);
        tick();
        check("halt_done", done[0], 1);
        check("halt_busy", busy[0], 0);
        check("halt_pc", pcv[0], 8'h00);
        for (int i = 0; i < 3; i++) tick();

        // start pulse during EX is ignored
        load_prog(0, 8'h00, 8'h01, 8'h12, 8'h34);
        expq.push_back({2'd0, 8'd12, 8'h46});
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n = 12;
        while (!done[0] && n < 100) begin
            tick();
            n++;
        end
        check("busy_start_cycles", n, 16);
        check("busy_start_pc", pcv[0], 8'h04);
        check("busy_start_pending", expq.size(), 0);

        // Two back-to-back instructions with ALU_LAT=5
        ram[2][0] = 8'h01; ram[2][1] = 8'd10; ram[2][2] = 8'd11; ram[2][3] = 8'd12;
        ram[2][4] = 8'h02; ram[2][5] = 8'd10; ram[2][6] = 8'd11; ram[2][7] = 8'd13;
        ram[2][8] = 8'hFF;
        ram[2][10] = 8'h09;
        ram[2][11] = 8'h04;
        expq.push_back({2'd2, 8'd12, 8'h0D});
        expq.push_back({2'd2, 8'd13, 8'h05});
        run(2, 200, n);
        check("lat5_cycles", n, 36);
        check("lat5_flags", fl[2], 2'b10);
        check("lat5_pc", pcv[2], 8'h08);
        check("lat5_pending", expq.size(), 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
